dec_2_4: RTL and testbench

Registered 2-to-4 decoder that reverses the 4-input priority encoder: it accepts encoded words {x, y, V} over a valid/ready handshake and returns the one-hot line D[3:0]. A 2-entry skid buffer holds words while downstream stalls, so the upstream handshake never has a combinational path to out_ready. It sits on the receiving side of any link carrying encoder output. It also counts received "no input active" words (V=0) for diagnostics.

---
 rtl/dec_2_4_if.sv | 24 ++
 rtl/dec_2_4.sv | 109 ++++++++++
 tb/tb_dec_2_4.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dec_2_4_if.sv
// dec_2_4_if: handshake bundle for the registered 2-to-4 decoder.
//   Upstream side : in_valid, in_ready, x, y, V (encoded word)
//   Downstream side: out_valid, out_ready, D (one-hot decoded line)
// slave  = decoder side, master = environment driving/consuming words.
interface dec_2_4_if;
  logic       in_valid;
  logic       in_ready;
  logic       x;
  logic       y;
  logic       V;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] D;

  modport slave (
    input  in_valid, x, y, V, out_ready,
    output in_ready, out_valid, D
  );

  modport master (
    output in_valid, x, y, V, out_ready,
    input  in_ready, out_valid, D
  );
endinterface

// File: rtl/dec_2_4.sv
// dec_2_4: registered 2-to-4 decoder behind a 2-entry skid buffer.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   bus      - dec_2_4_if.slave: in_valid/in_ready/x/y/V in, out_valid/out_ready/D out
//   clr      - synchronous clear of zero_cnt (data path unaffected)
//   zero_cnt - saturating count of accepted words with V=0
// Words are decoded at accept time; the buffer stores 4-bit one-hot words.
// in_ready is a flop, so there is no combinational path from out_ready to in_ready.
module dec_2_4 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  dec_2_4_if.slave         bus,
  input  logic             clr,
  output logic [CNT_W-1:0] zero_cnt
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] head;
  logic [3:0] head_nxt;
  logic [3:0] tail;
  logic [3:0] tail_nxt;
  logic [3:0] dec_word;
  logic       acc;
  logic       dlv;

  assign acc = bus.in_valid && bus.in_ready;
  assign dlv = bus.out_valid && bus.out_ready;

  always_comb begin
    dec_word = '0;
    if (bus.V) begin
      case ({bus.x, bus.y})
        2'b11:   dec_word = 4'b1000;
        2'b10:   dec_word = 4'b0100;
        2'b01:   dec_word = 4'b0010;
        default: dec_word = 4'b0001;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt = ONE;
          head_nxt  = dec_word;
        end
      end
      ONE: begin
        if (acc && !dlv) begin
          state_nxt = FULL;
          tail_nxt  = dec_word;
        end else if (!acc && dlv) begin
          state_nxt = EMPTY;
        end else if (acc && dlv) begin
          // head leaves and the incoming word replaces it in place
          head_nxt = dec_word;
        end
      end
      FULL: begin
        if (dlv) begin
          state_nxt = ONE;
          head_nxt  = tail;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      head         <= '0;
      tail         <= '0;
      bus.in_ready <= 1'b1;
    end else begin
      state        <= state_nxt;
      head         <= head_nxt;
      tail         <= tail_nxt;
      bus.in_ready <= (state_nxt != FULL);
    end
  end

  assign bus.out_valid = (state != EMPTY);
  assign bus.D         = (state == EMPTY) ? 4'b0000 : head;

  // clr wins over a same-cycle V=0 accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= '0;
    end else if (clr) begin
      zero_cnt <= '0;
    end else if (acc && !bus.V && (zero_cnt != '1)) begin
      zero_cnt <= zero_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dec_2_4.sv
// tb_dec_2_4: self-checking bench for dec_2_4 against a queue-based reference.
module tb_dec_2_4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr   = 1'b0;
  logic       clr_s = 1'b0;
  logic [7:0] zero_cnt;
  logic [1:0] zero_cnt_s;

  dec_2_4_if bus ();
  dec_2_4_if sbus ();

  dec_2_4 #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr      (clr),
    .zero_cnt (zero_cnt)
  );

  dec_2_4 #(.CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (sbus),
    .clr      (clr_s),
    .zero_cnt (zero_cnt_s)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // reference: FIFO of decoded words plus a saturating counter
  logic [3:0]  q[$];
  int unsigned m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] decode(input logic v, input logic [1:0] code);
    logic [3:0] one;
    one = 4'b0001;
    return v ? (one << code) : 4'b0000;
  endfunction

  // Compare outputs against the model, then advance one clock edge.
  task automatic cycle();
    bit         acc;
    bit         dlv;
    logic [3:0] w;
    check("in_ready",  bus.in_ready,  {31'd0, q.size() < 2});
    check("out_valid", bus.out_valid, {31'd0, q.size() > 0});
    check("D",         bus.D,         (q.size() > 0) ? {28'd0, q[0]} : 32'd0);
    check("zero_cnt",  zero_cnt,      m_cnt);
    acc = bus.in_valid && (q.size() < 2);
    dlv = (q.size() > 0) && bus.out_ready;
    w   = decode(bus.V, {bus.x, bus.y});
    @(posedge clk);
    if (dlv) void'(q.pop_front());
    if (acc) q.push_back(w);
    if (clr) m_cnt = 0;
    else if (acc && !bus.V && m_cnt < 255) m_cnt++;
    #1;
  endtask

  task automatic put(input logic [2:0] vxy);
    bus.in_valid = 1'b1;
    bus.V        = vxy[2];
    bus.x        = vxy[1];
    bus.y        = vxy[0];
  endtask

  logic [2:0] sweep_in [6] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b011};
  logic [3:0] sweep_d  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
  logic [1:0] sat_seq  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    bus.in_valid  = 1'b0;
    bus.x         = 1'b0;
    bus.y         = 1'b0;
    bus.V         = 1'b0;
    bus.out_ready = 1'b0;
    sbus.in_valid  = 1'b0;
    sbus.x         = 1'b0;
    sbus.y         = 1'b0;
    sbus.V         = 1'b0;
    sbus.out_ready = 1'b1;

    // power-on reset without a clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_D",         bus.D,         0);
    check("rst_zero_cnt",  zero_cnt,      0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // decode sweep, one word per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      put(sweep_in[i]);
      cycle();
      check("sweep_D", bus.D, {28'd0, sweep_d[i]});
    end
    bus.in_valid = 1'b0;
    cycle();
    check("sweep_cnt", zero_cnt, 2);
    cycle();

    // backpressure: 3 words offered, only 2 absorbed
    bus.out_ready = 1'b0;
    put(3'b100);
    cycle();
    put(3'b111);
    cycle();
    put(3'b110);
    cycle();
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_head", bus.D, 4'b0001);
    cycle();
    check("bp_hold_D", bus.D, 4'b0001);
    bus.out_ready = 1'b1;
    cycle();
    check("bp_second", bus.D, 4'b1000);
    check("bp_recover", bus.in_ready, 1);
    cycle();
    check("bp_third", bus.D, 4'b0100);
    bus.in_valid = 1'b0;
    cycle();
    cycle();

    // back-to-back accept+deliver in ONE
    for (int i = 0; i < 10; i++) begin
      put({1'b1, 2'($urandom_range(0, 3))});
      cycle();
      check("stream_in_ready", bus.in_ready, 1);
      check("stream_out_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    cycle();

    // asynchronous reset with the buffer full
    bus.out_ready = 1'b0;
    put(3'b000);
    cycle();
    put(3'b101);
    cycle();
    bus.in_valid = 1'b0;
    check("pre_rst_full", bus.in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  bus.in_ready,  1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_D",         bus.D,         0);
    check("mid_rst_zero_cnt",  zero_cnt,      0);
    q.delete();
    m_cnt = 0;
    #3 rst_n = 1'b1;
    cycle();
    bus.out_ready = 1'b1;
    put(3'b110);
    cycle();
    check("post_rst_D", bus.D, 4'b0100);
    bus.in_valid = 1'b0;
    cycle();
    check("post_rst_empty", bus.out_valid, 0);

    // saturation on the CNT_W=2 instance, then clr racing a V=0 accept
    sbus.in_valid = 1'b1;
    sbus.V        = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sbus.x = 1'($urandom_range(0, 1));
      sbus.y = 1'($urandom_range(0, 1));
      cycle();
      check("sat_cnt", zero_cnt_s, sat_seq[i]);
      check("sat_D", sbus.D, 0);
    end
    clr_s = 1'b1;
    cycle();
    clr_s = 1'b0;
    sbus.in_valid = 1'b0;
    check("sat_clr", zero_cnt_s, 0);

    // random handshake
    for (int i = 0; i < 1000; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.V         = ($urandom_range(0, 3) != 0);
      bus.x         = 1'($urandom_range(0, 1));
      bus.y         = 1'($urandom_range(0, 1));
      clr           = ($urandom_range(0, 31) == 0);
      cycle();
    end
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("drain_empty", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
